// File: rtl/xor_gate_share_ctrl_pkg.sv
// Shared types and constants for the XOR gate time-share controller.
// Imported by the controller top and its round-robin picker.
package xor_gate_share_ctrl_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StCapture = 2'd2
  } state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_gate_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, with wrap.
module xor_gate_share_ctrl_rr_pick
  import xor_gate_share_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IdxW-1:0]    ptr,
  output logic               valid,
  output logic [IdxW-1:0]    winner
);

  always_comb begin
    int unsigned idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/xor_gate_share_ctrl.sv
// Time-shares one quad 2-input XOR package between NUM_REQ requesters: grant round-robin,
// drive the gate pins, wait for the gate to settle, sample its outputs and ack the requester.
module xor_gate_share_ctrl
  import xor_gate_share_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LANES*NUM_REQ-1:0] op_a,
  input  logic [LANES*NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0]       ack,
  output logic [LANES-1:0]         result,
  output logic                     busy,
  output logic [LANES-1:0]         gate_a,
  output logic [LANES-1:0]         gate_b,
  input  logic [LANES-1:0]         gate_y
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      gidx_q, gidx_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LANES-1:0]     gate_a_q, gate_a_d;
  logic [LANES-1:0]     gate_b_q, gate_b_d;
  logic [LANES-1:0]     result_q, result_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 pick_valid;
  logic [IdxW-1:0]      winner;
  logic [LANES-1:0]     sel_a, sel_b;

  // The requester being acked is masked so a held req cannot be re-granted in its ack cycle.
  assign eligible = req & ~ack_q;

  xor_gate_share_ctrl_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .winner   (winner)
  );

  assign sel_a = op_a[32'(winner)*LANES +: LANES];
  assign sel_b = op_b[32'(winner)*LANES +: LANES];

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    result_d = result_q;
    ack_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gidx_d   = winner;
          gate_a_d = sel_a;
          gate_b_d = sel_b;
          cnt_d    = '0;
          ptr_d    = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        result_d      = gate_y;
        ack_d[gidx_q] = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gidx_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gate_a_q <= '0;
      gate_b_q <= '0;
      result_q <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      result_q <= result_d;
      ack_q    <= ack_d;
    end
  end

  assign ack    = ack_q;
  assign result = result_q;
  assign busy   = (state_q != StIdle);
  assign gate_a = gate_a_q;
  assign gate_b = gate_b_q;

endmodule

// File: tb/tb_xor_gate_share_ctrl.sv
// Scoreboard bench for xor_gate_share_ctrl: directed request patterns, delayed gate model,
// expected acks queued by the stimulus and checked by an independent monitor.
module tb_xor_gate_share_ctrl;

  localparam int unsigned NUM_REQ = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_REQ-1:0]  req = '0;
  logic [4*NUM_REQ-1:0] op_a;
  logic [4*NUM_REQ-1:0] op_b;
  logic [NUM_REQ-1:0]  ack;
  logic [3:0]          result;
  logic                busy;
  logic [3:0]          gate_a, gate_b, gate_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] res;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [3:0] prev_ack = '0;

  // Requester operands and hand-computed XOR results:
  // r0 A^6=C, r1 5^3=6, r2 9^4=D, r3 3^8=B.
  assign op_a = {4'h3, 4'h9, 4'h5, 4'hA};
  assign op_b = {4'h8, 4'h4, 4'h3, 4'h6};

  // Gate model with propagation delay shorter than the settle window.
  assign #3 gate_y = gate_a ^ gate_b;

  always #5 clk = ~clk;

  xor_gate_share_ctrl #(
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_a   (op_a),
    .op_b   (op_b),
    .ack    (ack),
    .result (result),
    .busy   (busy),
    .gate_a (gate_a),
    .gate_b (gate_b),
    .gate_y (gate_y)
  );

  // Monitor: every ack must match the head of the scoreboard and never repeat back to back.
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack=%b result=%h, none expected", ack, result);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || result !== e.res) begin
          errors++;
          $display("FAIL ack_result: got ack=%b result=%h, expected ack=%b result=%h",
                   ack, result, e.ack, e.res);
        end
      end
      checks++;
      if (prev_ack != '0) begin
        errors++;
        $display("FAIL back_to_back_ack: got ack=%b after ack=%b, expected a gap", ack, prev_ack);
      end
    end
    prev_ack <= rst ? '0 : ack;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic push(input int idx, input logic [3:0] res);
    exp_t x;
    x.ack = 4'(1 << idx);
    x.res = res;
    exp_q.push_back(x);
  endtask

  // Count falling edges until ack appears; an expired bound is a failure.
  task automatic wait_ack(output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack within 50 cycles, expected one");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (busy || ack != '0); i++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc;

    // Reset held with a pending request: nothing may happen.
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_gate_a", 32'(gate_a), 32'h0);
    chk("reset_gate_b", 32'(gate_b), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_result", 32'(result), 32'h0);
    push(0, 4'hC);
    rst = 1'b0;
    wait_ack(cyc);
    chk("first_latency", 32'(cyc), 32'd4);
    req = '0;
    wait_idle();

    // Fresh reset so the pointer restarts at requester 0, then all four contend.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(0, 4'hC); push(1, 4'h6); push(2, 4'hD); push(3, 4'hB); push(0, 4'hC);
    req = 4'b1111;
    wait_ack(cyc);
    for (int i = 1; i < 5; i++) begin
      wait_ack(cyc);
      chk("rr_spacing", 32'(cyc), 32'd4);
    end
    req = '0;
    wait_idle();

    // A lone held request: ack-cycle masking adds one idle cycle between its operations.
    push(2, 4'hD); push(2, 4'hD); push(2, 4'hD);
    req = 4'b0100;
    wait_ack(cyc);
    for (int i = 1; i < 3; i++) begin
      wait_ack(cyc);
      chk("single_spacing", 32'(cyc), 32'd5);
    end
    req = '0;
    wait_idle();

    // Serve 1, then 1 and 3 together: pointer sits at 2 so 3 wins first.
    push(1, 4'h6);
    req = 4'b0010;
    wait_ack(cyc);
    req = '0;
    wait_idle();
    push(3, 4'hB); push(1, 4'h6);
    req = 4'b1010;
    wait_ack(cyc);
    wait_ack(cyc);
    chk("pair_spacing", 32'(cyc), 32'd4);
    req = '0;
    wait_idle();

    // Reset mid-settle: the aborted operation gets no ack, pointer returns to 0.
    req = 4'b0100;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    chk("grant_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_ack", 32'(ack), 32'h0);
    chk("midreset_result", 32'(result), 32'h0);
    chk("midreset_gate_a", 32'(gate_a), 32'h0);
    chk("midreset_gate_b", 32'(gate_b), 32'h0);
    req = 4'b1010;
    @(negedge clk);
    push(1, 4'h6);
    rst = 1'b0;
    wait_ack(cyc);
    chk("post_reset_latency", 32'(cyc), 32'd4);
    req = '0;
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
